// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parking_pkg
// Purpose  : Shared lane-state encoding, sensor codes and popcount helper
//            for the parking-lot controller.
// Revision : 1.0  initial release
// ============================================================================
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        A1     = 3'd1,
        B1     = 3'd2,
        AB_IN  = 3'd3,
        AB_OUT = 3'd4,
        B_IN   = 3'd5,
        A_OUT  = 3'd6
    } lane_state_e;

    // Sensor pair codes: {a (outer), b (inner)}, 1 = beam blocked
    localparam logic [1:0] AB_CLEAR = 2'b00;
    localparam logic [1:0] AB_OUTER = 2'b10;
    localparam logic [1:0] AB_INNER = 2'b01;
    localparam logic [1:0] AB_BOTH  = 2'b11;

    localparam int c_MAX_LANES = 8;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parking_lot_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : parking_lot_ctrl_if
// Purpose  : Sensor-side inputs and barrier/display-side status outputs of
//            the parking-lot controller.
// Revision : 1.0  initial release
// ============================================================================
interface parking_lot_ctrl_if #(
    parameter int N_LANES  = 2,
    parameter int CAPACITY = 64
);
    localparam int CW = $clog2(CAPACITY + 1);

    logic [2*N_LANES-1:0] ab;
    logic                 clr_err;
    logic [N_LANES-1:0]   in_pulse;
    logic [N_LANES-1:0]   out_pulse;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;
    logic                 overflow_err;
    logic                 underflow_err;
    logic [N_LANES-1:0]   lane_abort;

    modport master (
        output ab, clr_err,
        input  in_pulse, out_pulse, count, full, empty,
               overflow_err, underflow_err, lane_abort
    );

    modport slave (
        input  ab, clr_err,
        output in_pulse, out_pulse, count, full, empty,
               overflow_err, underflow_err, lane_abort
    );

endinterface
`default_nettype wire

// File: rtl/parking_lane_fsm.sv
`default_nettype none
// ============================================================================
// Module   : parking_lane_fsm
// Purpose  : One gate lane: decodes the outer/inner sensor sequence into
//            entry/exit events. Optional stall timeout under LANE_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module parking_lane_fsm
    import parking_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [1:0] i_ab,
    output logic            o_entry_evt,
    output logic            o_exit_evt,
    output logic            o_in_pulse,
    output logic            o_out_pulse,
    output logic            o_abort
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    lane_state_e state_q, state_d;
    logic        in_pulse_q, out_pulse_q;
    logic        w_entry, w_exit;

`ifdef LANE_TIMEOUT_EN
    localparam int STW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STW-1:0] c_STALL_LAST = STW'(TIMEOUT_CYCLES - 1);

    logic [STW-1:0] stall_q, stall_d;
    logic [1:0]     ab_prev_q;
    logic           abort_q, abort_d;
`endif

    always_comb begin
        state_d = state_q;
        w_entry = 1'b0;
        w_exit  = 1'b0;
        case (state_q)
            IDLE:   if (i_ab == AB_OUTER) state_d = A1;
                    else if (i_ab == AB_INNER) state_d = B1;
            A1:     if (i_ab == AB_BOTH) state_d = AB_IN;
                    else if (i_ab == AB_CLEAR) state_d = IDLE;
            B1:     if (i_ab == AB_BOTH) state_d = AB_OUT;
                    else if (i_ab == AB_CLEAR) state_d = IDLE;
            AB_IN:  if (i_ab == AB_INNER) state_d = B_IN;
                    else if (i_ab == AB_OUTER) state_d = A1;
            AB_OUT: if (i_ab == AB_OUTER) state_d = A_OUT;
                    else if (i_ab == AB_INNER) state_d = B1;
            B_IN:   if (i_ab == AB_CLEAR) begin
                        state_d = IDLE;
                        w_entry = 1'b1;
                    end else if (i_ab == AB_BOTH) state_d = AB_IN;
            A_OUT:  if (i_ab == AB_CLEAR) begin
                        state_d = IDLE;
                        w_exit  = 1'b1;
                    end else if (i_ab == AB_BOTH) state_d = AB_OUT;
            default: state_d = IDLE;
        endcase

`ifdef LANE_TIMEOUT_EN
        // An unchanged ab never causes a transition, so the abort cannot
        // collide with an entry/exit event.
        abort_d = 1'b0;
        if (state_q == IDLE || i_ab != ab_prev_q) begin
            stall_d = '0;
        end else if (stall_q == c_STALL_LAST) begin
            stall_d = '0;
            state_d = IDLE;
            abort_d = 1'b1;
        end else begin
            stall_d = stall_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_pulse_q  <= 1'b0;
            out_pulse_q <= 1'b0;
`ifdef LANE_TIMEOUT_EN
            stall_q     <= '0;
            ab_prev_q   <= AB_CLEAR;
            abort_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_pulse_q  <= w_entry;
            out_pulse_q <= w_exit;
`ifdef LANE_TIMEOUT_EN
            stall_q     <= stall_d;
            ab_prev_q   <= i_ab;
            abort_q     <= abort_d;
`endif
        end
    end

    assign o_entry_evt = w_entry;
    assign o_exit_evt  = w_exit;
    assign o_in_pulse  = in_pulse_q;
    assign o_out_pulse = out_pulse_q;
`ifdef LANE_TIMEOUT_EN
    assign o_abort     = abort_q;
`else
    assign o_abort     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/parking_lot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : parking_lot_ctrl
// Purpose  : Multi-lane parking-lot controller: per-lane sequence FSMs feed a
//            saturating occupancy counter with full/empty and sticky errors.
//            Lane stall timeout is enabled by defining LANE_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module parking_lot_ctrl
    import parking_pkg::*;
#(
    parameter int N_LANES        = 2,
    parameter int CAPACITY       = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic          clk,
    input  wire logic          reset,
    parking_lot_ctrl_if.slave  bus
);

    localparam int CW = $clog2(CAPACITY + 1);
    localparam int SW = CW + 4;
    localparam logic signed [SW-1:0] c_CAP_S = SW'(CAPACITY);

    if (N_LANES < 1 || N_LANES > c_MAX_LANES) begin : g_bad_lanes
        $error("N_LANES must be in 1..8");
    end

    logic [N_LANES-1:0] w_entry_evt, w_exit_evt;
    logic [N_LANES-1:0] w_in_pulse, w_out_pulse, w_abort;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        parking_lane_fsm #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .i_ab        (bus.ab[2*i +: 2]),
            .o_entry_evt (w_entry_evt[i]),
            .o_exit_evt  (w_exit_evt[i]),
            .o_in_pulse  (w_in_pulse[i]),
            .o_out_pulse (w_out_pulse[i]),
            .o_abort     (w_abort[i])
        );
    end

    logic [CW-1:0]        count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 overflow_err_q, overflow_err_d;
    logic                 underflow_err_q, underflow_err_d;
    logic [3:0]           w_n_entry, w_n_exit;
    logic signed [SW-1:0] w_next;
    logic                 w_ovf_set, w_unf_set;

    always_comb begin
        w_n_entry = popcount8(8'(w_entry_evt));
        w_n_exit  = popcount8(8'(w_exit_evt));
        // Entries and exits net out first; only the net result saturates.
        w_next    = $signed({4'b0000, count_q})
                  + $signed({{CW{1'b0}}, w_n_entry})
                  - $signed({{CW{1'b0}}, w_n_exit});
        count_d   = w_next[CW-1:0];
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (w_next[SW-1]) begin
            count_d   = '0;
            w_unf_set = 1'b1;
        end else if (w_next > c_CAP_S) begin
            count_d   = CW'(CAPACITY);
            w_ovf_set = 1'b1;
        end
        full_d          = (count_d == CW'(CAPACITY));
        empty_d         = (count_d == '0);
        overflow_err_d  = w_ovf_set | (overflow_err_q  & ~bus.clr_err);
        underflow_err_d = w_unf_set | (underflow_err_q & ~bus.clr_err);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q         <= '0;
            full_q          <= 1'b0;
            empty_q         <= 1'b1;
            overflow_err_q  <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            count_q         <= count_d;
            full_q          <= full_d;
            empty_q         <= empty_d;
            overflow_err_q  <= overflow_err_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign bus.in_pulse      = w_in_pulse;
    assign bus.out_pulse     = w_out_pulse;
    assign bus.lane_abort    = w_abort;
    assign bus.count         = count_q;
    assign bus.full          = full_q;
    assign bus.empty         = empty_q;
    assign bus.overflow_err  = overflow_err_q;
    assign bus.underflow_err = underflow_err_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_lot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_lot_ctrl
// Purpose  : Directed self-checking bench for parking_lot_ctrl (three
//            parameterisations; timeout expectations follow LANE_TIMEOUT_EN).
// Revision : 1.0  initial release
// ============================================================================
module tb_parking_lot_ctrl;

`ifdef LANE_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    parking_lot_ctrl_if #(.N_LANES(2), .CAPACITY(64)) bus_m ();
    parking_lot_ctrl_if #(.N_LANES(2), .CAPACITY(4))  bus_c ();
    parking_lot_ctrl_if #(.N_LANES(4), .CAPACITY(64)) bus_n ();

    parking_lot_ctrl #(.N_LANES(2), .CAPACITY(64), .TIMEOUT_CYCLES(16)) dut_m (
        .clk (clk), .reset (reset), .bus (bus_m));
    parking_lot_ctrl #(.N_LANES(2), .CAPACITY(4), .TIMEOUT_CYCLES(16)) dut_c (
        .clk (clk), .reset (reset), .bus (bus_c));
    parking_lot_ctrl #(.N_LANES(4), .CAPACITY(64), .TIMEOUT_CYCLES(16)) dut_n (
        .clk (clk), .reset (reset), .bus (bus_n));

    task automatic step_m(input logic [3:0] v, input logic clr = 1'b0);
        bus_m.ab = v; bus_m.clr_err = clr;
        @(posedge clk); #1;
    endtask

    task automatic step_c(input logic [3:0] v, input logic clr = 1'b0);
        bus_c.ab = v; bus_c.clr_err = clr;
        @(posedge clk); #1;
    endtask

    task automatic step_n(input logic [7:0] v);
        bus_n.ab = v; bus_n.clr_err = 1'b0;
        @(posedge clk); #1;
    endtask

    // Full entry sequence on every lane of dut_n selected by m
    task automatic ent_n(input logic [3:0] m);
        logic [1:0] p;
        logic [7:0] v;
        for (int s = 0; s < 4; s++) begin
            p = (s == 0) ? 2'b10 : (s == 1) ? 2'b11 : (s == 2) ? 2'b01 : 2'b00;
            for (int i = 0; i < 4; i++) v[2*i +: 2] = m[i] ? p : 2'b00;
            step_n(v);
        end
    endtask

    task automatic entry_m0();
        step_m(4'b0010); step_m(4'b0011); step_m(4'b0001); step_m(4'b0000);
    endtask

    task automatic test_reset();
        checks++;
        if (bus_m.count !== 7'd0 || bus_m.empty !== 1'b1 || bus_m.full !== 1'b0) begin
            errors++;
            $display("FAIL reset_main count=%0d empty=%b full=%b exp 0/1/0",
                     bus_m.count, bus_m.empty, bus_m.full);
        end
        checks++;
        if ({bus_m.in_pulse, bus_m.out_pulse, bus_m.lane_abort,
             bus_m.overflow_err, bus_m.underflow_err} !== 8'd0) begin
            errors++;
            $display("FAIL reset_pulses in=%b out=%b abort=%b ovf=%b unf=%b exp all 0",
                     bus_m.in_pulse, bus_m.out_pulse, bus_m.lane_abort,
                     bus_m.overflow_err, bus_m.underflow_err);
        end
        checks++;
        if (bus_c.count !== 3'd0 || bus_c.empty !== 1'b1 ||
            bus_n.count !== 7'd0 || bus_n.empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_others c=%0d/%b n=%0d/%b exp 0/1",
                     bus_c.count, bus_c.empty, bus_n.count, bus_n.empty);
        end
    endtask

    task automatic test_entry_exit();
        step_m(4'b0010); step_m(4'b0011); step_m(4'b0001);
        checks++;
        if (bus_m.in_pulse !== 2'b00 || bus_m.count !== 7'd0) begin
            errors++;
            $display("FAIL entry_early in=%b count=%0d exp 00/0", bus_m.in_pulse, bus_m.count);
        end
        step_m(4'b0000);
        checks++;
        if (bus_m.in_pulse !== 2'b01 || bus_m.out_pulse !== 2'b00 ||
            bus_m.count !== 7'd1 || bus_m.empty !== 1'b0) begin
            errors++;
            $display("FAIL entry in=%b out=%b count=%0d empty=%b exp 01/00/1/0",
                     bus_m.in_pulse, bus_m.out_pulse, bus_m.count, bus_m.empty);
        end
        step_m(4'b0000);
        checks++;
        if (bus_m.in_pulse !== 2'b00 || bus_m.count !== 7'd1) begin
            errors++;
            $display("FAIL entry_one_cycle in=%b count=%0d exp 00/1", bus_m.in_pulse, bus_m.count);
        end
        step_m(4'b0001); step_m(4'b0011); step_m(4'b0010); step_m(4'b0000);
        checks++;
        if (bus_m.out_pulse !== 2'b01 || bus_m.in_pulse !== 2'b00 ||
            bus_m.count !== 7'd0 || bus_m.empty !== 1'b1) begin
            errors++;
            $display("FAIL exit out=%b in=%b count=%0d empty=%b exp 01/00/0/1",
                     bus_m.out_pulse, bus_m.in_pulse, bus_m.count, bus_m.empty);
        end
        step_m(4'b0000);
        checks++;
        if (bus_m.out_pulse !== 2'b00) begin
            errors++;
            $display("FAIL exit_one_cycle out=%b exp 00", bus_m.out_pulse);
        end
    endtask

    task automatic test_abort_underflow();
        logic seen;
        logic [3:0] pat [4];
        pat = '{4'b0010, 4'b0011, 4'b0010, 4'b0000};
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step_m(pat[k]);
            if (bus_m.in_pulse !== 2'b00 || bus_m.out_pulse !== 2'b00) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || bus_m.count !== 7'd0) begin
            errors++;
            $display("FAIL aborted_entry pulse_seen=%b count=%0d exp 0/0", seen, bus_m.count);
        end
        step_m(4'b0001); step_m(4'b0011); step_m(4'b0010); step_m(4'b0000);
        checks++;
        if (bus_m.out_pulse !== 2'b01 || bus_m.count !== 7'd0 ||
            bus_m.underflow_err !== 1'b1 || bus_m.overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL underflow out=%b count=%0d unf=%b ovf=%b exp 01/0/1/0",
                     bus_m.out_pulse, bus_m.count, bus_m.underflow_err, bus_m.overflow_err);
        end
        step_m(4'b0000);
        checks++;
        if (bus_m.underflow_err !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky unf=%b exp 1", bus_m.underflow_err);
        end
    endtask

    task automatic test_clr_err();
        step_m(4'b0000, 1'b1);
        checks++;
        if (bus_m.underflow_err !== 1'b0) begin
            errors++;
            $display("FAIL clr_err unf=%b exp 0", bus_m.underflow_err);
        end
        step_m(4'b0001); step_m(4'b0011); step_m(4'b0010); step_m(4'b0000, 1'b1);
        checks++;
        if (bus_m.underflow_err !== 1'b1 || bus_m.count !== 7'd0) begin
            errors++;
            $display("FAIL clr_set_wins unf=%b count=%0d exp 1/0", bus_m.underflow_err, bus_m.count);
        end
        step_m(4'b0000, 1'b1);
        step_m(4'b0000);
    endtask

    task automatic test_lane_independence();
        entry_m0();
        // lane 0 exits while lane 1 enters, completing together
        step_m(4'b1001); step_m(4'b1111); step_m(4'b0110); step_m(4'b0000);
        checks++;
        if (bus_m.in_pulse !== 2'b10 || bus_m.out_pulse !== 2'b01 || bus_m.count !== 7'd1 ||
            bus_m.overflow_err !== 1'b0 || bus_m.underflow_err !== 1'b0) begin
            errors++;
            $display("FAIL net_events in=%b out=%b count=%0d ovf=%b unf=%b exp 10/01/1/0/0",
                     bus_m.in_pulse, bus_m.out_pulse, bus_m.count,
                     bus_m.overflow_err, bus_m.underflow_err);
        end
        // lane 1 parked in A1 while lane 0 completes an entry
        step_m(4'b1010); step_m(4'b1011); step_m(4'b1001); step_m(4'b1000);
        checks++;
        if (bus_m.in_pulse !== 2'b01 || bus_m.count !== 7'd2) begin
            errors++;
            $display("FAIL independent in=%b count=%0d exp 01/2", bus_m.in_pulse, bus_m.count);
        end
        step_m(4'b0000);
        checks++;
        if (bus_m.in_pulse !== 2'b00 || bus_m.count !== 7'd2) begin
            errors++;
            $display("FAIL lane1_backout in=%b count=%0d exp 00/2", bus_m.in_pulse, bus_m.count);
        end
    endtask

    task automatic test_timeout();
        logic seen;
        // 15 cycles stalled in AB_IN: no abort, sequence still completes
        step_m(4'b1000); step_m(4'b1100);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step_m(4'b1100);
            if (bus_m.lane_abort !== 2'b00) seen = 1'b1;
        end
        step_m(4'b0100);
        if (bus_m.lane_abort !== 2'b00) seen = 1'b1;
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL timeout_15 abort_seen=%b exp 0", seen);
        end
        step_m(4'b0000);
        checks++;
        if (bus_m.in_pulse !== 2'b10 || bus_m.count !== 7'd3) begin
            errors++;
            $display("FAIL timeout_15_entry in=%b count=%0d exp 10/3", bus_m.in_pulse, bus_m.count);
        end
        // 16 cycles stalled in AB_IN
        step_m(4'b1000); step_m(4'b1100);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step_m(4'b1100);
            if (bus_m.lane_abort !== 2'b00) seen = 1'b1;
        end
        step_m(4'b1100);
        checks++;
        if (seen !== 1'b0 || bus_m.lane_abort !== (TMO ? 2'b10 : 2'b00) || bus_m.count !== 7'd3) begin
            errors++;
            $display("FAIL timeout_16 early=%b abort=%b count=%0d exp 0/%b/3",
                     seen, bus_m.lane_abort, bus_m.count, TMO ? 2'b10 : 2'b00);
        end
        step_m(4'b1100);
        checks++;
        if (bus_m.lane_abort !== 2'b00) begin
            errors++;
            $display("FAIL abort_one_cycle abort=%b exp 00", bus_m.lane_abort);
        end
        step_m(4'b0100); step_m(4'b0000);
        checks++;
        if (bus_m.in_pulse !== (TMO ? 2'b00 : 2'b10) || bus_m.count !== (TMO ? 7'd3 : 7'd4)) begin
            errors++;
            $display("FAIL timeout_after in=%b count=%0d exp %b/%0d", bus_m.in_pulse,
                     bus_m.count, TMO ? 2'b00 : 2'b10, TMO ? 3 : 4);
        end
    endtask

    task automatic test_capacity();
        for (int k = 0; k < 4; k++) begin
            step_c(4'b0010); step_c(4'b0011); step_c(4'b0001); step_c(4'b0000);
        end
        checks++;
        if (bus_c.count !== 3'd4 || bus_c.full !== 1'b1 || bus_c.empty !== 1'b0 ||
            bus_c.overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL cap_fill count=%0d full=%b empty=%b ovf=%b exp 4/1/0/0",
                     bus_c.count, bus_c.full, bus_c.empty, bus_c.overflow_err);
        end
        step_c(4'b0110); step_c(4'b1111); step_c(4'b1001); step_c(4'b0000);
        checks++;
        if (bus_c.count !== 3'd4 || bus_c.in_pulse !== 2'b01 || bus_c.out_pulse !== 2'b10 ||
            bus_c.overflow_err !== 1'b0 || bus_c.underflow_err !== 1'b0 || bus_c.full !== 1'b1) begin
            errors++;
            $display("FAIL cap_net count=%0d in=%b out=%b ovf=%b unf=%b full=%b exp 4/01/10/0/0/1",
                     bus_c.count, bus_c.in_pulse, bus_c.out_pulse,
                     bus_c.overflow_err, bus_c.underflow_err, bus_c.full);
        end
        step_c(4'b0001); step_c(4'b0011); step_c(4'b0010); step_c(4'b0000);
        checks++;
        if (bus_c.count !== 3'd3 || bus_c.full !== 1'b0) begin
            errors++;
            $display("FAIL cap_exit count=%0d full=%b exp 3/0", bus_c.count, bus_c.full);
        end
        step_c(4'b1010); step_c(4'b1111); step_c(4'b0101); step_c(4'b0000);
        checks++;
        if (bus_c.count !== 3'd4 || bus_c.full !== 1'b1 || bus_c.overflow_err !== 1'b1 ||
            bus_c.in_pulse !== 2'b11) begin
            errors++;
            $display("FAIL overflow count=%0d full=%b ovf=%b in=%b exp 4/1/1/11",
                     bus_c.count, bus_c.full, bus_c.overflow_err, bus_c.in_pulse);
        end
        step_c(4'b0000, 1'b1);
        checks++;
        if (bus_c.overflow_err !== 1'b0 || bus_c.count !== 3'd4) begin
            errors++;
            $display("FAIL ovf_clear ovf=%b count=%0d exp 0/4", bus_c.overflow_err, bus_c.count);
        end
        step_c(4'b0000);
    endtask

    task automatic test_all_lanes();
        ent_n(4'b1111);
        ent_n(4'b1111);
        ent_n(4'b0001);
        ent_n(4'b0001);
        checks++;
        if (bus_n.count !== 7'd10) begin
            errors++;
            $display("FAIL n4_preload count=%0d exp 10", bus_n.count);
        end
        ent_n(4'b1111);
        checks++;
        if (bus_n.count !== 7'd14 || bus_n.in_pulse !== 4'b1111 || bus_n.out_pulse !== 4'b0000) begin
            errors++;
            $display("FAIL n4_all_entry count=%0d in=%b out=%b exp 14/1111/0000",
                     bus_n.count, bus_n.in_pulse, bus_n.out_pulse);
        end
    endtask

    task automatic test_reset_mid();
        int cur;
        cur = TMO ? 3 : 4;
        for (int k = cur; k < 5; k++) entry_m0();
        checks++;
        if (bus_m.count !== 7'd5) begin
            errors++;
            $display("FAIL mid_preload count=%0d exp 5", bus_m.count);
        end
        step_m(4'b0010); step_m(4'b0011);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus_m.count !== 7'd0 || bus_m.empty !== 1'b1 || bus_m.full !== 1'b0 ||
            bus_m.in_pulse !== 2'b00 || bus_m.out_pulse !== 2'b00 || bus_c.count !== 3'd0 ||
            bus_n.count !== 7'd0) begin
            errors++;
            $display("FAIL async_reset count=%0d empty=%b full=%b in=%b out=%b c=%0d n=%0d exp 0/1/0/00/00/0/0",
                     bus_m.count, bus_m.empty, bus_m.full, bus_m.in_pulse, bus_m.out_pulse,
                     bus_c.count, bus_n.count);
        end
        @(negedge clk);
        reset = 1'b0;
        step_m(4'b0001); step_m(4'b0000);
        checks++;
        if (bus_m.in_pulse !== 2'b00 || bus_m.count !== 7'd0) begin
            errors++;
            $display("FAIL reset_lane_idle in=%b count=%0d exp 00/0", bus_m.in_pulse, bus_m.count);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus_m.ab = '0; bus_m.clr_err = 1'b0;
        bus_c.ab = '0; bus_c.clr_err = 1'b0;
        bus_n.ab = '0; bus_n.clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        test_entry_exit();
        test_abort_underflow();
        test_clr_err();
        test_lane_independence();
        test_timeout();
        test_capacity();
        test_all_lanes();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parking_lot_ctrl.md
Name: parking_lot_ctrl

Overview:
Multi-lane parking-lot controller. Each of N_LANES gate lanes has an outer/inner sensor pair decoded by a per-lane sequence FSM into entry/exit events. A shared occupancy counter tracks cars against CAPACITY and drives full/empty status plus sticky over/underflow errors. It sits between the gate sensor synchronisers and the barrier/display logic.

Parameters:
N_LANES, 2, number of independent gate lanes (1..8)
CAPACITY, 64, maximum occupancy; count saturates here
CW, $clog2(CAPACITY+1), count width (derived localparam, not overridable)
TIMEOUT_CYCLES, 1024, stall limit for a partial sequence (used only with LANE_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ab  in  2*N_LANES  sensor pairs, already synchronised; lane i: ab[2i+1]=a (outer), ab[2i]=b (inner), 1=beam blocked
clr_err  in  1  synchronous clear of sticky error flags
in_pulse  out  N_LANES  one-cycle registered pulse per completed entry
out_pulse  out  N_LANES  one-cycle registered pulse per completed exit
count  out  CW  current occupancy
full  out  1  count == CAPACITY
empty  out  1  count == 0
overflow_err  out  1  sticky: an entry was dropped at CAPACITY
underflow_err  out  1  sticky: an exit was dropped at 0
lane_abort  out  N_LANES  one-cycle pulse when a lane sequence times out (0 without macro)

Behaviour:
- Reset (async assert): lane FSMs to IDLE, count=0, empty=1, full=0, every pulse and error output 0.
- Lane FSM states/transitions on ab pair (unlisted inputs hold state):
  IDLE: 10->A1, 01->B1
  A1: 11->AB_IN, 00->IDLE
  B1: 11->AB_OUT, 00->IDLE
  AB_IN: 01->B_IN, 10->A1
  AB_OUT: 10->A_OUT, 01->B1
  B_IN: 00->IDLE (entry event), 11->AB_IN
  A_OUT: 00->IDLE (exit event), 11->AB_OUT
- Event timing: on the edge where a lane takes B_IN->IDLE (A_OUT->IDLE), in_pulse[i] (out_pulse[i]) rises for exactly one cycle and the count updates on that same edge. No combinational path from ab to any output.
- Arithmetic: E = popcount(entry events), X = popcount(exit events) in the cycle; next = count + E - X, computed at CW+4 bits signed.
- If next > CAPACITY: count=CAPACITY, overflow_err set. If next < 0: count=0, underflow_err set. Pulses still assert for every lane event, including dropped ones.
- Simultaneous entries and exits net out before saturation. Example: count=CAPACITY with E=1, X=1 gives count unchanged and no error.
- full/empty are registered and consistent with count in the same cycle.
- clr_err clears both errors. If a new error occurs in the same cycle, the set wins.
- Lanes are fully independent. A lane's behaviour must not depend on other lanes' activity.

Optional Feature:
LANE_TIMEOUT_EN: when defined, each lane has a stall counter of width $clog2(TIMEOUT_CYCLES+1).
- The counter resets whenever that lane's ab changes or the lane is IDLE.
- If the lane stays non-IDLE with ab unchanged for TIMEOUT_CYCLES consecutive cycles, the lane forces to IDLE and lane_abort[i] pulses for one cycle. No entry/exit event and no count change.
- Without the macro: no counters, lane_abort is tied to 0, and lanes can wait indefinitely.

Decomposition:
- Package parking_pkg: lane state enum (IDLE, A1, B1, AB_IN, AB_OUT, B_IN, A_OUT); sensor encodings AB_CLEAR=00, AB_OUTER=10, AB_INNER=01, AB_BOTH=11.
- Sub-module parking_lane_fsm: one lane's FSM, registered event pulses and optional timeout. It is instantiated N_LANES times by a generate loop.
- The top level holds the popcount, the saturating counter and the flags.

Test Plan:
- Reset mid-sequence (lane 0 in AB_IN, count=5), assert reset async -> all outputs zero immediately, count=0, empty=1.
- Lane 0 entry 00,10,11,01,00 -> in_pulse[0] high for exactly one cycle, count 0->1, empty falls in the same cycle; reverse sequence -> out_pulse[0], count 1->0.
- Aborted entry 00,10,11,10,00 -> no pulse, count unchanged. Then exit at count=0 -> out_pulse asserts, count stays 0, underflow_err=1; clr_err clears it.
- CAPACITY=4, count=4, lane 0 entry and lane 1 exit completing in the same cycle -> count stays 4, no error. Two simultaneous entries at count=3 -> count=4, full=1, overflow_err=1.
- N_LANES=4, all lanes complete an entry in the same cycle from count=10 -> count=14, four in_pulse bits high together.
- With LANE_TIMEOUT_EN and TIMEOUT_CYCLES=16, hold lane 1 at 11 in AB_IN for 16 cycles -> lane_abort[1] pulses, lane returns to IDLE, count unchanged. At 15 cycles -> no abort.
